fifo_push_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of one FIFO instance among N_REQ requesters.
- Keeps its own occupancy (credit) count of the downstream FIFO and only grants when a slot is guaranteed. The FIFO full flag is therefore never needed on the push path.
- Drives a registered push/data pair straight into the FIFO's push and data inputs.

---
 rtl/fifo_push_arbiter_if.sv | 22 ++
 rtl/fifo_push_arbiter.sv | 76 +++++++
 tb/tb_fifo_push_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_push_arbiter_if.sv
// rtl/fifo_push_arbiter_if.sv - requester and FIFO write-port signals of the push arbiter
interface fifo_push_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic                   fifo_push;
    logic [WIDTH-1:0]       fifo_data;
    logic                   pop_done;

    modport master (
        input  req, req_data, pop_done,
        output ack, fifo_push, fifo_data
    );

    modport slave (
        output req, req_data, pop_done,
        input  ack, fifo_push, fifo_data
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - credit-gated round-robin arbiter sharing one FIFO write port
module fifo_push_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int IDW  = $clog2(N_REQ),
    localparam int UW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_push_arbiter_if.master   bus,
    input  logic                  hold,
    output logic [UW-1:0]         used,
    output logic [IDW-1:0]        grant_id,
    output logic                  err
);

    logic             found;
    logic [IDW-1:0]   win;
    logic             grant;
    logic [N_REQ-1:0] ack_c;
    logic             push_q;
    logic [WIDTH-1:0] data_q;
    int               cand;

    // Search starts one past the last winner so priority rotates only on grants.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(grant_id) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = IDW'(cand);
            end
        end
    end

    // A full credit count blocks grants even when a pop lands this cycle.
    assign grant = !rst && !hold && found && (used < UW'(DEPTH));

    always_comb begin
        ack_c = '0;
        if (grant) ack_c[win] = 1'b1;
    end

    assign bus.ack       = ack_c;
    assign bus.fifo_push = push_q;
    assign bus.fifo_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            push_q   <= 1'b0;
            data_q   <= '0;
            used     <= '0;
            err      <= 1'b0;
            grant_id <= IDW'(N_REQ - 1);
        end else begin
            push_q <= grant;
            if (grant) begin
                data_q   <= bus.req_data[win*WIDTH +: WIDTH];
                grant_id <= win;
            end
            // Credit is taken at grant time, one cycle before the push reaches the FIFO.
            if (grant && !bus.pop_done) begin
                used <= used + 1'b1;
            end else if (!grant && bus.pop_done) begin
                if (used != '0) used <= used - 1'b1;
                else            err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - scoreboard bench for fifo_push_arbiter
module tb_fifo_push_arbiter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         hold;
    logic [2:0]   used;
    logic [1:0]   grant_id;
    logic         err;

    fifo_push_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    fifo_push_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hold     (hold),
        .used     (used),
        .grant_id (grant_id),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int        m_used = 0;
    int        m_last = N - 1;
    int        m_err  = 0;
    int        exp_q[$];
    bit        mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check combinational ack against the model, then advance the model.
    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d,
                         input logic p, input logic h, input logic rs,
                         output logic [N-1:0] a_obs);
        int  w;
        bit  g;
        int  idx;
        logic [N*W-1:0] dv;
        @(negedge clk);
        bus.req      = r;
        bus.req_data = d;
        bus.pop_done = p;
        hold         = h;
        rst          = rs;
        #1;
        g = 1'b0;
        w = 0;
        if (!rs && !h && m_used < D) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!g && r[idx]) begin
                    g = 1'b1;
                    w = idx;
                end
            end
        end
        chk("ack", int'(bus.ack), g ? (1 << w) : 0);
        a_obs = bus.ack;
        @(posedge clk);
        if (rs) begin
            m_used = 0;
            m_err  = 0;
            m_last = N - 1;
            exp_q.delete();
        end else begin
            if (g) begin
                dv     = d;
                m_last = w;
                exp_q.push_back(int'(dv[w*W +: W]));
            end
            if (g && !p)       m_used++;
            else if (!g && p) begin
                if (m_used > 0) m_used--;
                else            m_err = 1;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("fifo_push", int'(bus.fifo_push), (exp_q.size() != 0) ? 1 : 0);
            if (bus.fifo_push && exp_q.size() != 0)
                chk("fifo_data", int'(bus.fifo_data), exp_q.pop_front());
            chk("used", int'(used), m_used);
            chk("grant_id", int'(grant_id), m_last);
            chk("err", int'(err), m_err);
        end
    end

    initial begin
        logic [N-1:0]   a;
        logic [N*W-1:0] d;
        bit             p;
        bit             h;
        bit             rs;
        bus.req = '0; bus.req_data = '0; bus.pop_done = 1'b0; hold = 1'b0; rst = 1'b1;

        cycle(4'b0000, '0, 1'b0, 1'b0, 1'b1, a);
        cycle(4'b1111, '0, 1'b0, 1'b0, 1'b1, a);
        chk("rst_ack", int'(a), 0);
        chk("rst_used", int'(used), 0);
        chk("rst_grant_id", int'(grant_id), N - 1);
        chk("rst_push", int'(bus.fifo_push), 0);
        mon_en = 1'b1;

        // Fill from reset with all requesters active.
        d = 16'h9C5A;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, d, 1'b0, 1'b0, 1'b0, a);
            chk("fill_ack", int'(a), (i < 4) ? (1 << i) : 0);
        end
        chk("fill_used", int'(used), 4);

        // Pop at full: bubble, then grant the freed slot.
        cycle(4'b0001, $urandom, 1'b1, 1'b0, 1'b0, a);
        chk("full_pop_ack", int'(a), 0);
        chk("full_pop_used", int'(used), 3);
        cycle(4'b0001, $urandom, 1'b0, 1'b0, 1'b0, a);
        chk("after_pop_ack", int'(a), 1);
        chk("after_pop_used", int'(used), 4);

        // Grant and pop in the same cycle.
        cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0, a);
        cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0, a);
        cycle(4'b0001, $urandom, 1'b1, 1'b0, 1'b0, a);
        chk("gp_ack", int'(a), 1);
        chk("gp_used", int'(used), 2);

        // Wrap-around after requester 2, then hold freezes priority.
        cycle(4'b0100, $urandom, 1'b0, 1'b0, 1'b0, a);
        chk("r2_ack", int'(a), 4);
        cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0, a);
        cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0, a);
        d = $urandom;
        cycle(4'b0101, d, 1'b0, 1'b0, 1'b0, a);
        chk("wrap_ack0", int'(a), 1);
        cycle(4'b0101, d, 1'b0, 1'b0, 1'b0, a);
        chk("wrap_ack2", int'(a), 4);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0101, d, 1'b0, 1'b1, 1'b0, a);
            chk("hold_ack", int'(a), 0);
        end
        chk("hold_grant_id", int'(grant_id), 2);

        // Drain, underflow, sticky error.
        for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0, a);
        chk("drain_used", int'(used), 0);
        cycle(4'b0000, '0, 1'b1, 1'b0, 1'b0, a);
        chk("uf_err", int'(err), 1);
        chk("uf_used", int'(used), 0);
        cycle(4'b1111, $urandom, 1'b0, 1'b0, 1'b0, a);
        cycle(4'b1111, $urandom, 1'b1, 1'b0, 1'b0, a);
        chk("err_sticky", int'(err), 1);

        // Reset right after a grant.
        cycle(4'b1111, $urandom, 1'b0, 1'b0, 1'b1, a);
        chk("mid_rst_ack", int'(a), 0);
        chk("mid_rst_used", int'(used), 0);
        chk("mid_rst_err", int'(err), 0);
        cycle(4'b0110, $urandom, 1'b0, 1'b0, 1'b0, a);
        chk("post_rst_ack", int'(a), 2);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            d  = {$urandom, $urandom};
            h  = ($urandom_range(0, 5) == 0);
            p  = (m_used > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 79) == 0);
            rs = ($urandom_range(0, 99) == 0);
            cycle(N'($urandom_range(0, 15)), d, p, h, rs, a);
        end
        cycle(4'b0000, '0, 1'b0, 1'b0, 1'b0, a);
        cycle(4'b0000, '0, 1'b0, 1'b0, 1'b0, a);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
